// File: rtl/comm_delay_line_pkg.sv
// Shared definitions for the communication delay line and its users.
// Provides the select-width helper, the delay clamp and legacy instance defaults.
// The framing controller reuses clamp_dly so both sides agree on the effective tap.
package comm_delay_line_pkg;

  // Defaults for the done-strobe instance, matching the legacy 10-stage 1-bit chain
  localparam int DONE_WL    = 1;
  localparam int DONE_DEPTH = 10;

  // Width of a select port able to express 0..depth
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Map a requested delay onto the usable tap range 1..depth
  function automatic int clamp_dly(input int dly, input int depth);
    if (dly <= 0) begin
      return 1;
    end else if (dly > depth) begin
      return depth;
    end else begin
      return dly;
    end
  endfunction

endpackage

// File: rtl/comm_delay_stage.sv
// One {valid, data} register stage of the delay line.
// Latency: 1 enabled edge.
// Backpressure: none; en=0 holds the stage, clear and reset zero it regardless of en.
module comm_delay_stage #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset beats clear beats enable; otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/comm_delay_line.sv
// Delays a word plus valid flag by a run-time tap of 1..DEPTH enabled cycles, tracks fill, pulses done on rising lvl.
// Latency: D enabled edges input-to-tap; oDONE one clock after the tap level rises.
// Backpressure: iEN=0 stalls every stage and the fill counter; the edge tracker keeps running every clock.
module comm_delay_line
  import comm_delay_line_pkg::*;
#(
  parameter  int WL    = 1,
  parameter  int DEPTH = 16,
  localparam int SELW  = sel_width(DEPTH)
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            iCLR,
  input  logic            iEN,
  input  logic            iVALID,
  input  logic [WL-1:0]   iDATA,
  input  logic [SELW-1:0] iDLY,
  output logic [WL-1:0]   oDATA,
  output logic            oVALID,
  output logic            oPRIMED,
  output logic            oDONE
);

  // stg[0] is the live input; stg[1..DEPTH] are registered stages
  logic [WL:0]     stg [DEPTH+1];
  logic [SELW-1:0] tap_sel;
  logic [WL:0]     tap;
  logic [SELW-1:0] cnt;
  logic            lvl;
  logic            prev;

  assign stg[0] = {iVALID, iDATA};

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    comm_delay_stage #(
      .W (WL + 1)
    ) u_stage (
      .clk   (iCLK),
      .rst_n (iRSTn),
      .clr   (iCLR),
      .en    (iEN),
      .d     (stg[k-1]),
      .q     (stg[k])
    );
  end

  // Clamped tap select; never 0, so the mux only ever picks a register output
  assign tap_sel = SELW'(clamp_dly(int'(iDLY), DEPTH));
  assign tap     = stg[tap_sel];
  assign oVALID  = tap[WL];
  assign oDATA   = tap[WL-1:0];
  assign lvl     = tap[WL] & tap[0];
  assign oPRIMED = (cnt >= tap_sel);

  // Fill counter: counts enabled shifts since flush, saturating at DEPTH
  always_ff @(posedge iCLK) begin
    if (!iRSTn || iCLR) begin
      cnt <= '0;
    end else if (iEN && (cnt != SELW'(DEPTH))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Rising-edge detector on the tap level, clocked every cycle independent of iEN
  always_ff @(posedge iCLK) begin
    if (!iRSTn || iCLR) begin
      prev  <= 1'b0;
      oDONE <= 1'b0;
    end else begin
      prev  <= lvl;
      oDONE <= lvl & ~prev;
    end
  end

endmodule

// File: tb/tb_comm_delay_line.sv
// Directed bench for comm_delay_line (WL=8, DEPTH=10) with a queue scoreboard.
module tb_comm_delay_line;

  localparam int WL    = 8;
  localparam int DEPTH = 10;
  localparam int SELW  = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            clr;
  logic            en;
  logic            vld;
  logic [WL-1:0]   dat;
  logic [SELW-1:0] dly;
  logic [WL-1:0]   o_data;
  logic            o_valid;
  logic            o_primed;
  logic            o_done;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [8:0] q [$];
  logic [8:0] last;
  logic       l1;
  logic       l2;
  int         filled;
  int         cur_d;

  comm_delay_line #(
    .WL    (WL),
    .DEPTH (DEPTH)
  ) dut (
    .iCLK    (clk),
    .iRSTn   (rstn),
    .iCLR    (clr),
    .iEN     (en),
    .iVALID  (vld),
    .iDATA   (dat),
    .iDLY    (dly),
    .oDATA   (o_data),
    .oVALID  (o_valid),
    .oPRIMED (o_primed),
    .oDONE   (o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    q.delete();
    last   = '0;
    l1     = 1'b0;
    l2     = 1'b0;
    filled = 0;
  endtask

  // One clock: push on enabled edges, pop the word that has travelled cur_d edges
  task automatic step(input logic e, input logic v, input logic [7:0] d, input string tag);
    en  = e;
    vld = v;
    dat = d;
    l2  = l1;
    l1  = last[8] & last[0];
    @(posedge clk);
    #1;
    if (e) begin
      q.push_back({v, d});
      if (q.size() == cur_d) last = q.pop_front();
      if (filled < DEPTH) filled++;
    end
    chk({tag, "_tap"},    32'({o_valid, o_data}), 32'(last));
    chk({tag, "_done"},   32'(o_done),            32'(l1 & ~l2));
    chk({tag, "_primed"}, 32'(o_primed),          32'(filled >= cur_d));
  endtask

  task automatic do_clear(input logic e, input string tag);
    clr = 1'b1;
    en  = e;
    vld = 1'b1;
    dat = 8'hFF;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk({tag, "_data"},   32'(o_data),   32'h0);
    chk({tag, "_valid"},  32'(o_valid),  32'h0);
    chk({tag, "_primed"}, 32'(o_primed), 32'h0);
    chk({tag, "_done"},   32'(o_done),   32'h0);
    model_flush();
  endtask

  initial begin
    // Reset held 2 clocks with enable and all-ones input
    rstn = 1'b0; clr = 1'b0; en = 1'b1; vld = 1'b1; dat = 8'hFF; dly = 4'd10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",   32'(o_data),   32'h0);
    chk("rst_valid",  32'(o_valid),  32'h0);
    chk("rst_primed", 32'(o_primed), 32'h0);
    chk("rst_done",   32'(o_done),   32'h0);
    rstn = 1'b1;
    model_flush();

    // Legacy: single 1 travels the full 10-stage chain, no dead cycle after reset
    cur_d = 10;
    step(1'b1, 1'b1, 8'h01, "leg");
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 8'h00, "leg");

    // Clear mid-stream with enable: in-flight and current words are discarded
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h55, "pre_clr");
    do_clear(1'b1, "clr");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00, "post_clr");

    // Stall: three words with 3-clock gaps, stalled inputs must be ignored
    dly = 4'd4; cur_d = 4;
    do_clear(1'b0, "clr_stall");
    step(1'b1, 1'b1, 8'h11, "stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE, "stall");
    step(1'b1, 1'b1, 8'h22, "stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE, "stall");
    step(1'b1, 1'b1, 8'h33, "stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hEE, "stall");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00, "stall_flush");

    // Clamp low: iDLY=0 behaves as 1
    dly = 4'd0; cur_d = 1;
    do_clear(1'b0, "clr_lo");
    step(1'b1, 1'b1, 8'hA1, "clamp_lo");
    step(1'b1, 1'b1, 8'hB2, "clamp_lo");
    step(1'b1, 1'b1, 8'hC3, "clamp_lo");
    step(1'b1, 1'b0, 8'h00, "clamp_lo");

    // Clamp high: iDLY=15 behaves as DEPTH
    dly = 4'd15; cur_d = DEPTH;
    do_clear(1'b0, "clr_hi");
    step(1'b1, 1'b1, 8'h5D, "clamp_hi");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00, "clamp_hi");

    // Dynamic tap: s1..s4 = 06,05,04,03 then move tap 3 -> 4
    dly = 4'd3; cur_d = 3;
    do_clear(1'b0, "clr_dyn");
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 8'(i), "dyn_fill");
    en = 1'b0;
    @(posedge clk); #1;
    chk("dyn_quiet_done", 32'(o_done), 32'h0);
    dly = 4'd4;
    #1;
    chk("dyn_tap4",    32'({o_valid, o_data}), 32'h103);
    chk("dyn_primed4", 32'(o_primed),          32'h1);
    @(posedge clk); #1;
    chk("dyn_pulse", 32'(o_done), 32'h1);
    @(posedge clk); #1;
    chk("dyn_pulse_end", 32'(o_done), 32'h0);
    @(posedge clk); #1;
    chk("dyn_no_retrig", 32'(o_done), 32'h0);
    dly = 4'd7;
    #1;
    chk("dyn_unprimed7", 32'(o_primed), 32'h0);
    dly = 4'd6;
    #1;
    chk("dyn_primed6", 32'(o_primed), 32'h1);

    // Saturation: 3*DEPTH enabled clocks, counter must not wrap
    dly = 4'd10; cur_d = DEPTH;
    do_clear(1'b0, "clr_sat");
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 1'($urandom), 8'($urandom), "sat");
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dly = 4'(i);
      #1;
      chk("sat_primed_all_dly", 32'(o_primed), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
